// File: rtl/svc_rv_lsu_ctrl.sv
// svc_rv_lsu_ctrl: load/store sequencer between the RV execute stage and a single-port data memory.
// Latency: request accepted in cycle 0, mem_valid in cycle 1, load response no earlier than cycle 3.
// Backpressure: one access in flight; mem_* held until mem_ready, rsp_* held until rsp_ready.
// Optional: define SVC_RV_LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of issuing them.
module svc_rv_lsu_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_fault
);

  // Lane arithmetic below assumes a 4-byte word.
  if (XLEN != 32) begin : g_xlen_check
    $error("svc_rv_lsu_ctrl: only XLEN=32 is supported");
  end

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_req_ready;
  logic            r_mem_valid;
  logic            r_rsp_valid;
  logic [2:0]      r_funct3;
  logic [1:0]      r_addr_lo;
  logic [XLEN-1:0] r_mem_addr;
  logic            r_mem_we;
  logic [3:0]      r_mem_wstrb;
  logic [XLEN-1:0] r_mem_wdata;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_fault;

  logic            w_accept;
  logic            w_mem_hs;
  logic            w_rd_hs;
  logic            w_trap;
  logic [3:0]      w_st_strb;
  logic [XLEN-1:0] w_st_data;
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [XLEN-1:0] w_ld_data;

  // req_ready is a register so it reads 0 throughout reset and the cycle after release.
  assign w_accept = r_req_ready & req_valid;
  assign w_mem_hs = r_mem_valid & mem_ready;
  // Read data is only meaningful while waiting; stray rvalid elsewhere is dropped here.
  assign w_rd_hs  = (r_state == S_WAIT) & mem_rvalid;

`ifdef SVC_RV_LSU_MISALIGN_TRAP_EN
  logic w_misaligned;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  always_comb begin
    w_misaligned = 1'b0;
    if (req_funct3 == F3_W) begin
      w_misaligned = (req_addr[1:0] != 2'b00);
    end else if ((req_funct3 == F3_H) || (!req_we && (req_funct3 == F3_HU))) begin
      w_misaligned = req_addr[0];
    end
  end

  assign w_trap = w_misaligned;
`else
  // Misaligned accesses go to memory; low address bits only steer the lanes.
  assign w_trap = 1'b0;
`endif

  // Store lane steering: place right-justified data on every lane, strobe the addressed ones.
  always_comb begin
    w_st_strb = 4'b0000;
    w_st_data = req_wdata;
    case (req_funct3)
      F3_B: begin
        w_st_strb = 4'b0001 << req_addr[1:0];
        w_st_data = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        w_st_strb = req_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{req_wdata[15:0]}};
      end
      F3_W: begin
        w_st_strb = 4'b1111;
      end
      default: begin
        w_st_strb = 4'b0000;
      end
    endcase
  end

  // Load formatting: pick the addressed byte/half and extend per funct3.
  always_comb begin
    case (r_addr_lo)
      2'd0:    w_ld_byte = mem_rdata[7:0];
      2'd1:    w_ld_byte = mem_rdata[15:8];
      2'd2:    w_ld_byte = mem_rdata[23:16];
      default: w_ld_byte = mem_rdata[31:24];
    endcase
    w_ld_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    w_ld_data = mem_rdata;
    case (r_funct3)
      F3_B:    w_ld_data = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      F3_H:    w_ld_data = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
      F3_W:    w_ld_data = mem_rdata;
      F3_BU:   w_ld_data = {{(XLEN-8){1'b0}}, w_ld_byte};
      F3_HU:   w_ld_data = {{(XLEN-16){1'b0}}, w_ld_half};
      default: w_ld_data = mem_rdata;
    endcase
  end

  // Next-state logic for the single-outstanding access sequence.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_trap ? S_RESP : S_REQ;
        end
      end
      S_REQ: begin
        if (w_mem_hs) begin
          w_next = r_mem_we ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Registered handshake flags and access/response payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready <= 1'b0;
      r_mem_valid <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wstrb <= 4'b0000;
      r_mem_wdata <= '0;
      r_rsp_data  <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      r_req_ready <= (w_next == S_IDLE);
      r_mem_valid <= (w_next == S_REQ);
      r_rsp_valid <= (w_next == S_RESP);
      if (w_accept) begin
        r_funct3    <= req_funct3;
        r_addr_lo   <= req_addr[1:0];
        r_mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
        r_mem_we    <= req_we;
        r_mem_wstrb <= req_we ? w_st_strb : 4'b0000;
        r_mem_wdata <= req_we ? w_st_data : '0;
        r_rsp_data  <= '0;
        r_rsp_fault <= w_trap;
      end else if (w_rd_hs) begin
        r_rsp_data  <= w_ld_data;
      end
    end
  end

  assign req_ready = r_req_ready;
  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wstrb = r_mem_wstrb;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_fault = r_rsp_fault;

endmodule

// File: doc/svc_rv_lsu_ctrl.md
Name: svc_rv_lsu_ctrl

Overview:
- Load/store sequencer between the RV execute stage and a single-port data memory.
- Accepts one load or store per transaction and drives a valid/ready memory request.
- For loads, waits for read data, then extracts the addressed byte/half and applies sign/zero extension.
- Returns result or fault to the pipeline with a valid/ready handshake; at most one access is outstanding.

Parameters:
- XLEN, 32, data/address width; only 32 is supported, other values are an elaboration error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  pipeline access request
- req_ready  out  1  controller can accept a request
- req_we  in  1  1=store, 0=load
- req_funct3  in  3  RV LOAD/STORE funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, right-justified
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts request
- mem_addr  out  XLEN  word address (bits[1:0]=0)
- mem_we  out  1  write enable
- mem_wstrb  out  4  byte write strobes
- mem_wdata  out  XLEN  lane-aligned store data
- mem_rvalid  in  1  read data valid (load only)
- mem_rdata  in  XLEN  read word
- rsp_valid  out  1  completion valid
- rsp_ready  in  1  pipeline accepts completion
- rsp_data  out  XLEN  formatted load data; 0 for stores and faults
- rsp_fault  out  1  misaligned access (feature on only)

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP. Reset (async, immediate) -> IDLE.
- Reset values: req_ready=0, mem_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, rsp_valid=0, rsp_data=0, rsp_fault=0.
- IDLE: req_ready=1. On req_valid, register we/funct3/addr/wdata and go to REQ. If the feature is on and the access is misaligned, go straight to RESP with fault=1 and do not access memory.
- REQ: mem_valid=1. All mem_* outputs come from registers and stay stable until mem_ready. On mem_valid&mem_ready, a store goes to RESP and a load goes to WAIT.
- WAIT: on mem_rvalid, capture the formatted mem_rdata into rsp_data and go to RESP. Any mem_rvalid seen outside WAIT is ignored.
- RESP: rsp_valid=1, and rsp_data/rsp_fault stay stable. On rsp_ready, go to IDLE.
  - req_ready stays 0, so there is no back-to-back overlap.
  - Minimum load latency: accept at cycle 0, mem_valid at cycle 1, rvalid at cycle 2 at earliest, rsp_valid at cycle 3.
- Store lane alignment by addr[1:0]:
  - SB: wstrb=0001<<addr, data = wdata[7:0] replicated x4.
  - SH: wstrb = addr[1] ? 1100 : 0011, data = wdata[15:0] replicated x2.
  - SW: wstrb=1111, data=wdata.
- Load format:
  - Byte select by addr[1:0], half select by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Undefined funct3: a load returns the raw word; a store uses wstrb=0000 and still handshakes.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
- Reset mid-transaction abandons the access. mem_valid drops immediately, and a subsequent stray mem_rvalid is ignored.

Optional Feature:
- Macro SVC_RV_LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests complete in RESP with rsp_fault=1, rsp_data=0, and no mem_valid.
- Undefined: rsp_fault is tied to 0, and misaligned accesses are issued with the low address bits ignored for the word address, with lane selection as above.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF_1234 -> mem_addr=0x100, mem_we=0, rsp_data=0xFFFF_FF80; LBU same -> 0x0000_0080.
- LH at 0x202, mem_rdata=0x8001_7FFF -> rsp_data=0xFFFF_8001; LHU -> 0x0000_8001; LW at 0x200 -> 0x8001_7FFF.
- SB at 0x301, wdata=0xDEAD_BEA5 -> mem_wstrb=0010, mem_wdata=0xA5A5_A5A5; rsp_valid follows the handshake with rsp_data=0 and no mem_rvalid required.
- Backpressure: hold mem_ready=0 for 5 cycles, then rsp_ready=0 for 3 cycles -> mem_* and rsp_* outputs stay stable; req_ready=0 throughout; exactly one mem handshake.
- Feature on: LW at 0x402 -> rsp_fault=1, rsp_data=0, mem_valid never asserted. Feature off: same request -> mem_addr=0x400, rsp_fault=0.
- Assert rst while in WAIT -> all outputs return to reset values immediately; a later mem_rvalid produces no rsp_valid; the next request completes normally.
